// File: rtl/operand_entry_pkg.sv
// Shared types for operand_entry: the entry FSM states and the LED stage codes.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [1:0] STAGE_ENTER_A = 2'd0;
  localparam logic [1:0] STAGE_ENTER_B = 2'd1;
  localparam logic [1:0] STAGE_SHOW    = 2'd2;

  function automatic logic [1:0] stage_of(input state_t s);
    case (s)
      ENTER_A: stage_of = STAGE_ENTER_A;
      ENTER_B: stage_of = STAGE_ENTER_B;
      SHOW:    stage_of = STAGE_SHOW;
      default: stage_of = STAGE_ENTER_A;
    endcase
  endfunction

endpackage

// File: rtl/operand_entry_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce counter is built only when OPERAND_ENTRY_DEBOUNCE_EN is defined.
module btn_conditioner
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             accepted_q;

  // The run counter restarts whenever the synchronized level agrees with the
  // accepted one, so only an unbroken run of DEBOUNCE_CYCLES flips it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      accepted_q <= 1'b0;
    end else if (sync_q2 == accepted_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      accepted_q <= sync_q2;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = accepted_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync_q2;
`endif

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/operand_entry.sv
// Operand loader FSM: captures A, then B plus operation, then enables the datapath.
// Optional button debounce is selected by OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_sel,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] input_a,
  output logic [WIDTH-1:0] input_b,
  output logic             mux_sel,
  output logic             en,
  output logic [1:0]       stage
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic             en_q, en_d;
  logic             press;
  logic             clr_q1, clr_q2;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_next),
    .press(press)
  );

  // Clear is level-sensitive, so it only needs synchronizing, not debouncing.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q1 <= 1'b0;
      clr_q2 <= 1'b0;
    end else begin
      clr_q1 <= btn_clear;
      clr_q2 <= clr_q1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    en_d    = en_q;
    if (clr_q2) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = 1'b0;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        ENTER_A: if (press) begin
          a_d     = sw;
          state_d = ENTER_B;
        end
        ENTER_B: if (press) begin
          b_d     = sw;
          sel_d   = sw_sel;
          en_d    = 1'b1;
          state_d = SHOW;
        end
        SHOW: if (press) begin
          en_d    = 1'b0;
          state_d = ENTER_A;
        end
        default: begin
          state_d = ENTER_A;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
    end
  end

  assign input_a = a_q;
  assign input_b = b_q;
  assign mux_sel = sel_q;
  assign en      = en_q;
  assign stage   = stage_of(state_q);

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios plus random button/clear traffic
// compared every cycle against a behavioural model of the entry sequence.
module tb_operand_entry;

  localparam int W = 4;
  localparam int D = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam bit DB      = 1'b1;
  localparam int PRESS_LAT = 2 + D;
`else
  localparam bit DB      = 1'b0;
  localparam int PRESS_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic         sw_sel;
  logic         btn_next;
  logic         btn_clear;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         mux_sel;
  logic         en;
  logic [1:0]   stage;

  operand_entry #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .sw_sel   (sw_sel),
    .btn_next (btn_next),
    .btn_clear(btn_clear),
    .input_a  (input_a),
    .input_b  (input_b),
    .mux_sel  (mux_sel),
    .en       (en),
    .stage    (stage)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: raw sample histories, the window of synchronized levels,
  // the accepted button level and the user-visible registers.
  bit       bh[$];
  bit       ch[$];
  bit       lq[$];
  bit       acc, acc_d;
  int       m_state;
  bit [W-1:0] m_a, m_b;
  bit       m_sel, m_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit lvl, clv, press, all_diff;
    if (rst) begin
      bh.delete(); ch.delete(); lq.delete();
      acc = 0; acc_d = 0;
      m_state = 0; m_a = '0; m_b = '0; m_sel = 0; m_en = 0;
    end else begin
      lvl = (bh.size() >= 2) ? bh[bh.size()-2] : 1'b0;
      clv = (ch.size() >= 2) ? ch[ch.size()-2] : 1'b0;
      if (!DB) begin
        acc   = lvl;
        press = acc && !acc_d;
        acc_d = acc;
      end else begin
        press = acc && !acc_d;
        acc_d = acc;
        lq.push_back(lvl);
        if (lq.size() > D) void'(lq.pop_front());
        if (lq.size() == D) begin
          all_diff = 1;
          foreach (lq[i]) if (lq[i] == acc) all_diff = 0;
          if (all_diff) acc = ~acc;
        end
      end
      if (clv) begin
        m_state = 0; m_a = '0; m_b = '0; m_sel = 0; m_en = 0;
      end else if (press) begin
        case (m_state)
          0: begin m_a = sw; m_state = 1; end
          1: begin m_b = sw; m_sel = sw_sel; m_en = 1; m_state = 2; end
          default: begin m_en = 0; m_state = 0; end
        endcase
      end
      bh.push_back(btn_next);
      ch.push_back(btn_clear);
      if (bh.size() > 2) void'(bh.pop_front());
      if (ch.size() > 2) void'(ch.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("input_a", 32'(input_a), 32'(m_a));
    check("input_b", 32'(input_b), 32'(m_b));
    check("mux_sel", 32'(mux_sel), 32'(m_sel));
    check("en",      32'(en),      32'(m_en));
    check("stage",   32'(stage),   32'(m_state));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Raise btn_next and return the edge index at which stage first changes.
  task automatic press_and_time(output int n);
    logic [1:0] s0;
    s0 = stage;
    btn_next = 1'b1;
    n = 0;
    step();
    while (stage == s0 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic press_release(input int hold);
    btn_next = 1'b1;
    steps(hold);
    btn_next = 1'b0;
    steps(PRESS_LAT + 6);
  endtask

  int n;

  initial begin
    rst = 1'b1; sw = '0; sw_sel = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    steps(3);
    rst = 1'b0;

    // Idle after reset
    steps(20);
    check("idle_a", 32'(input_a), 32'd0);
    check("idle_en", 32'(en), 32'd0);
    check("idle_stage", 32'(stage), 32'd0);

    // Capture A then B with subtract
    sw = 4'h9;
    press_and_time(n);
    check("lat_a", 32'(n), 32'(PRESS_LAT));
    btn_next = 1'b0;
    steps(PRESS_LAT + 6);
    sw = 4'h3; sw_sel = 1'b1;
    press_and_time(n);
    check("lat_b", 32'(n), 32'(PRESS_LAT));
    btn_next = 1'b0;
    steps(PRESS_LAT + 6);
    check("cap_a", 32'(input_a), 32'h9);
    check("cap_b", 32'(input_b), 32'h3);
    check("cap_sel", 32'(mux_sel), 32'd1);
    check("cap_en", 32'(en), 32'd1);
    check("cap_stage", 32'(stage), 32'd2);

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    // Bounce with 3-cycle pulses, then hold: one advance from SHOW
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1; steps(3);
      btn_next = 1'b0; steps(3);
    end
    check("bounce_stage", 32'(stage), 32'd2);
    btn_next = 1'b1;
    steps(20);
    btn_next = 1'b0;
    steps(12);
    check("bounce_adv", 32'(stage), 32'd0);
    check("bounce_keep_a", 32'(input_a), 32'h9);
    sw = 4'h6; press_release(8);
    sw = 4'h5; sw_sel = 1'b0; press_release(8);
`endif

    // Long hold in SHOW
    check("hold_pre", 32'(stage), 32'd2);
    press_release(50);
    check("hold_stage", 32'(stage), 32'd0);
    check("hold_en", 32'(en), 32'd0);
    check("hold_keep_b", 32'(input_b), DB ? 32'h5 : 32'h3);

    // Clear together with a press while in ENTER_B
    sw = 4'h7; press_release(8);
    btn_clear = 1'b1; btn_next = 1'b1;
    n = 0;
    step();
    while (stage != 2'd0 && n < 40) begin
      step();
      n++;
    end
    check("clr_lat", 32'(n), 32'd2);
    steps(30);
    btn_clear = 1'b0; btn_next = 1'b0;
    steps(15);
    check("clr_stage", 32'(stage), 32'd0);
    check("clr_a", 32'(input_a), 32'd0);
    check("clr_b", 32'(input_b), 32'd0);

    // Reset mid-sequence
    sw = 4'hc; press_release(8);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_a", 32'(input_a), 32'd0);
    steps(4);

    // Randomized button, clear, switch and occasional reset traffic
    for (int k = 0; k < 300; k++) begin
      btn_next  = 1'($urandom_range(0, 1));
      btn_clear = ($urandom_range(0, 19) == 0);
      sw        = W'($urandom);
      sw_sel    = 1'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      step();
      rst = 1'b0;
      steps($urandom_range(0, 11));
    end
    btn_next = 1'b0; btn_clear = 1'b0;
    steps(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
